// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one fixed-latency memory port between fetch and data
//            requesters, with data priority and a fetch starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int STREAK_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_be,
  output logic        mem_write_en,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_WAIT    = 2'd1;
  localparam logic [1:0] c_ST_RESP    = 2'd2;
  localparam logic [3:0] c_LAT_INIT   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] c_STREAK_MAX = 4'(STREAK_MAX);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_owner_d;
  logic        r_we;
  logic        r_wen;
  logic [3:0]  r_lat;
  logic [3:0]  r_streak;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        w_d_win;
  logic        w_if_win;
  logic        w_sample;

  // Data wins unless fetch has already been passed over STREAK_MAX times.
  assign w_d_win  = !halted && d_req && !(if_req && (r_streak == c_STREAK_MAX));
  assign w_if_win = !halted && if_req && !w_d_win;
  assign w_sample = (r_state == c_ST_WAIT) && (r_lat == 4'd0);

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: if (w_d_win || w_if_win) w_next_state = c_ST_WAIT;
      c_ST_WAIT: if (r_lat == 4'd0) w_next_state = c_ST_RESP;
      c_ST_RESP: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  // Grants are suppressed while reset is held so outputs read 0 in reset.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    busy      = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        d_gnt  = w_d_win && !rst_b;
        if_gnt = w_if_win && !rst_b;
      end
      c_ST_WAIT: busy = 1'b1;
      c_ST_RESP: begin
        busy      = 1'b1;
        d_rvalid  = r_owner_d;
        if_rvalid = !r_owner_d;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_wen      <= 1'b0;
      r_lat      <= 4'd0;
      r_streak   <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      if (if_gnt || d_gnt) begin
        r_owner_d <= d_gnt;
        r_addr    <= d_gnt ? d_addr : if_addr;
        r_we      <= d_gnt && d_we;
        r_wen     <= d_gnt && d_we;
        r_lat     <= c_LAT_INIT;
        if (d_gnt) begin
          r_wdata <= d_wdata;
          r_be    <= d_be;
        end
      end else begin
        r_wen <= 1'b0;
        if ((r_state == c_ST_WAIT) && (r_lat != 4'd0)) begin
          r_lat <= r_lat - 4'd1;
        end
      end

      if (if_gnt) begin
        r_streak <= 4'd0;
      end else if (d_gnt) begin
        if (!if_req) begin
          r_streak <= 4'd0;
        end else if (r_streak != c_STREAK_MAX) begin
          r_streak <= r_streak + 4'd1;
        end
      end

      if (w_sample) begin
        if (r_owner_d) begin
          r_d_rdata <= r_we ? 32'd0 : mem_data_out;
        end else begin
          r_if_rdata <= mem_data_out;
        end
      end
    end
  end

  assign mem_addr     = r_addr;
  assign mem_data_in  = r_wdata;
  assign mem_be       = r_be;
  assign mem_write_en = r_wen;
  assign if_rdata     = r_if_rdata;
  assign d_rdata      = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed scoreboard bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        halted;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_be;
  logic        mem_write_en;
  logic [31:0] mem_data_out;
  logic        busy;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_be(mem_be),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        e_mon;
  logic        gnt_log[$];
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  int          tests   = 0;
  int          fails   = 0;
  int          cyc     = 0;
  int          we_cnt  = 0;
  int          gnt_cnt = 0;

  // Byte-lane memory seen by the DUT.
  assign mem_data_out = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectations pushed at grant, popped at rvalid.
  always @(negedge clk) begin
    if (mem_write_en === 1'b1) we_cnt++;
    if (!rst_b) begin
      chk("one_hot_gnt", 32'(if_gnt & d_gnt), 32'd0);
      if (if_gnt || d_gnt) begin
        gnt_cnt++;
        gnt_log.push_back(d_gnt);
      end
      if (if_gnt) q.push_back('{1'b0, ref_mem[if_addr[9:2]], cyc + LAT + 1});
      if (d_gnt) begin
        if (d_we) begin
          for (int b = 0; b < 4; b++) begin
            if (d_be[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
          end
          q.push_back('{1'b1, 32'd0, cyc + LAT + 1});
        end else begin
          q.push_back('{1'b1, ref_mem[d_addr[9:2]], cyc + LAT + 1});
        end
      end
      if (if_rvalid || d_rvalid) begin
        if (q.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        end else begin
          e_mon = q.pop_front();
          chk("rvalid_owner", {30'd0, if_rvalid, d_rvalid}, e_mon.is_d ? 32'd1 : 32'd2);
          chk("rdata", e_mon.is_d ? d_rdata : if_rdata, e_mon.data);
          chk("resp_cycle", 32'(cyc), 32'(e_mon.due));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(if_gnt || d_gnt) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(if_gnt || d_gnt)) chk({tag, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_write_en, busy}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_data_in"}, mem_data_in, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_order [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int   n;
    rst_b = 1'b1; halted = 1'b0; if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    mem[0]     = 32'h0050_0093;
    ref_mem[0] = 32'h0050_0093;

    // Reset state, with a fetch already requested.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");

    // Single fetch from 0x0; held request is granted in the first IDLE cycle.
    tick();
    rst_b = 1'b0;
    @(negedge clk);
    chk("t1_if_gnt", 32'(if_gnt), 32'd1);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_mem_addr", mem_addr, 32'h0);
    chk("t1_busy_wait", 32'(busy), 32'd1);
    repeat (LAT + 1) @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_rvalid_pulse", 32'(if_rvalid), 32'd0);
    chk("t1_rdata_hold", if_rdata, 32'h0050_0093);

    // Second fetch; address changes after grant must not leak through.
    tick();
    if_req = 1'b1; if_addr = 32'h24;
    wait_gnt("t1b");
    tick();
    if_req = 1'b0; if_addr = 32'hFFC;
    @(negedge clk);
    chk("t1b_mem_addr", mem_addr, 32'h24);
    wait_idle("t1b");

    // Full-word store, partial store, then load back.
    tick();
    we_cnt = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    wait_gnt("t2_st");
    tick();
    d_req = 1'b0;
    wait_idle("t2_st");
    chk("t2_we_pulses", 32'(we_cnt), 32'd1);
    chk("t2_st_rdata", d_rdata, 32'd0);

    tick();
    we_cnt = 0;
    d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h1234_5678; d_be = 4'h3;
    wait_gnt("t2_pst");
    tick();
    d_req = 1'b0;
    wait_idle("t2_pst");
    chk("t2_pst_we_pulses", 32'(we_cnt), 32'd1);

    tick();
    d_req = 1'b1; d_we = 1'b0;
    wait_gnt("t2_ld");
    tick();
    d_req = 1'b0;
    wait_idle("t2_ld");
    chk("t2_ld_rdata_hold", d_rdata, 32'hDEAD_5678);

    // Contention with both requests held: D, D, IF repeating.
    tick();
    gnt_log.delete();
    if_addr = 32'h0; d_addr = 32'h100; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    n = 0;
    while (gnt_log.size() < 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tick();
    if_req = 1'b0; d_req = 1'b0;
    chk("t3_grant_count", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
      chk($sformatf("t3_order_%0d", i), 32'(gnt_log[i]), 32'(exp_order[i]));
    end
    wait_idle("t3");

    // Halt during a load: it completes, nothing else is granted until release.
    tick();
    d_addr = 32'h8; d_we = 1'b0; d_req = 1'b1;
    wait_gnt("t4");
    tick();
    halted = 1'b1; if_req = 1'b1;
    gnt_cnt = 0;
    repeat (8) @(negedge clk);
    chk("t4_no_gnt_halted", 32'(gnt_cnt), 32'd0);
    chk("t4_load_done", 32'(q.size()), 32'd0);
    tick();
    halted = 1'b0;
    @(negedge clk);
    chk("t4_resume_d_gnt", 32'(d_gnt), 32'd1);
    chk("t4_resume_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    d_req = 1'b0; if_req = 1'b0;
    wait_idle("t4");

    // Reset during a store before its write cycle.
    tick();
    we_cnt = 0;
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D; d_be = 4'hF; d_req = 1'b1;
    wait_gnt("t5");
    #1;
    rst_b = 1'b1;
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h4;
    q.delete();
    @(negedge clk);
    chk_all_zero("t5_reset");
    tick();
    rst_b = 1'b0;
    @(negedge clk);
    chk("t5_if_gnt_first_idle", 32'(if_gnt), 32'd1);
    chk("t5_no_write", 32'(we_cnt), 32'd0);
    tick();
    if_req = 1'b0;
    wait_idle("t5");

    // Requests arriving in RESP are not granted until the following IDLE.
    tick();
    if_addr = 32'h0; if_req = 1'b1;
    wait_gnt("t6");
    tick();
    if_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!if_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_resp", 32'(if_rvalid), 32'd1);
    #1;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    #1;
    chk("t6_no_gnt_resp", {30'd0, if_gnt, d_gnt}, 32'd0);
    @(negedge clk);
    chk("t6_d_gnt_next", 32'(d_gnt), 32'd1);
    chk("t6_if_gnt_next", 32'(if_gnt), 32'd0);
    tick();
    if_req = 1'b0; d_req = 1'b0;
    wait_idle("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
